// File: rtl/alu_mdu_ctl.sv
// alu_mdu_ctl: base-ISA ALU decode plus an iterative RV32M multiply/divide
// sequencer that stalls the core until the result is ready.
// Optional build macro: MDU_EARLY_OUT_EN. When it is defined, divide-by-zero,
// signed divide overflow and any multiply with a zero operand skip the
// iterative steps and go straight to DONE.
module alu_mdu_ctl #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    input  logic               flush,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_imm,
    output logic               stall,
    output logic               mdu_sel,
    output logic [XLEN-1:0]    mdu_result,
    output logic               busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    localparam logic [ALUOP_W-1:0] ALU_SUM  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_LT   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_LTU  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(15);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Per-operation context latched at launch; fn[2] distinguishes divide.
    typedef struct packed {
        logic [2:0] fn;
        logic       neg_q;  // negate product / quotient magnitude
        logic       neg_r;  // negate remainder magnitude (dividend sign)
        logic       dz;     // divide by zero: quotient forced to all-ones
    } mdu_ctx_t;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    assign opcode = instruction[6:0];
    assign funct7 = instruction[31:25];
    assign funct3 = instruction[14:12];

    logic unused_bits;

    // funct3 -> ALU op for OP / OP-IMM; alt is funct7[5], which selects SUB only for register ops
    function automatic logic [ALUOP_W-1:0] fn_op(input logic [2:0] f3, input logic alt,
                                                 input logic is_reg);
        case (f3)
            3'b000:  fn_op = (is_reg && alt) ? ALU_SUB : ALU_SUM;
            3'b001:  fn_op = ALU_SLL;
            3'b010:  fn_op = ALU_LT;
            3'b011:  fn_op = ALU_LTU;
            3'b100:  fn_op = ALU_XOR;
            3'b101:  fn_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  fn_op = ALU_OR;
            default: fn_op = ALU_AND;
        endcase
    endfunction

    // Base-ISA ALU decode, purely combinational and independent of the MDU
    always_comb begin
        alu_op  = ALU_NOP;
        alu_imm = 1'b0;
        case (opcode)
            OPC_OP:    if (funct7 != F7_MEXT) alu_op = fn_op(funct3, funct7[5], 1'b1);
            OPC_IMM:   alu_op = fn_op(funct3, funct7[5], 1'b0);
            OPC_LOAD,
            OPC_STORE,
            OPC_AUIPC: alu_op = ALU_SUM;
            default:   alu_op = ALU_NOP;
        endcase
        alu_imm = (opcode == OPC_IMM) || (opcode == OPC_LOAD) || (opcode == OPC_STORE) ||
                  (opcode == OPC_AUIPC) || (opcode == OPC_LUI);
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [XLEN-1:0]       b_q;
    mdu_ctx_t              ctx_q;

    logic                  is_mop;
    logic                  launch;
    logic                  early;
    logic                  a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    mdu_ctx_t              op_ctx;
    logic [2*XLEN-1:0]     acc_init;

    assign is_mop = (opcode == OPC_OP) && (funct7 == F7_MEXT);
    assign launch = (state_q == S_IDLE) && instr_valid && is_mop && !flush;

    // Operand preparation at launch: magnitudes plus sign flags
    always_comb begin
        a_sgn  = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        b_sgn  = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
        a_neg  = a_sgn & rs1_data[XLEN-1];
        b_neg  = b_sgn & rs2_data[XLEN-1];
        a_mag  = a_neg ? -rs1_data : rs1_data;
        b_mag  = b_neg ? -rs2_data : rs2_data;
        op_ctx.fn    = funct3;
        op_ctx.neg_q = a_neg ^ b_neg;
        op_ctx.neg_r = a_neg;
        op_ctx.dz    = funct3[2] && (rs2_data == '0);
    end

`ifdef MDU_EARLY_OUT_EN
    logic op_ovf, op_mzero;
    // Short-circuit cases preload the accumulator with the final magnitudes
    always_comb begin
        op_ovf   = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (&rs2_data);
        op_mzero = !funct3[2] && ((rs1_data == '0) || (rs2_data == '0));
        early    = op_ctx.dz || op_ovf || op_mzero;
        if (op_mzero)       acc_init = '0;
        else if (op_ctx.dz) acc_init = {a_mag, {XLEN{1'b1}}};
        else                acc_init = {{XLEN{1'b0}}, a_mag};
    end
`else
    assign early    = 1'b0;
    assign acc_init = {{XLEN{1'b0}}, a_mag};
`endif

    // One radix-2 step: shift-add multiply or restoring divide on the accumulator
    logic [XLEN:0]         mul_sum;
    logic [2*XLEN:0]       div_sh;
    logic [XLEN:0]         div_diff;
    logic [2*XLEN-1:0]     acc_step;
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {acc_q, 1'b0};
        div_diff = div_sh[2*XLEN:XLEN] - {1'b0, b_q};
        if (ctx_q.fn[2]) begin
            if (div_sh[2*XLEN:XLEN] >= {1'b0, b_q})
                acc_step = {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
            else
                acc_step = div_sh[2*XLEN-1:0];
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    assign unused_bits = ^{instruction[24:15], instruction[11:7], div_diff[XLEN]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, stall and result mux; flush always returns to IDLE
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q_fix, r_fix;
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        busy       = 1'b0;
        mdu_sel    = 1'b0;
        mdu_result = '0;
        prod       = ctx_q.neg_q ? -acc_q : acc_q;
        q_fix      = ctx_q.dz ? {XLEN{1'b1}}
                              : (ctx_q.neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        r_fix      = ctx_q.neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (state_q)
            S_IDLE: begin
                stall = launch;
                if (launch) state_d = early ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
            end
            S_DONE: begin
                mdu_sel = 1'b1;
                state_d = S_IDLE;
                if (ctx_q.fn[2])            mdu_result = ctx_q.fn[1] ? r_fix : q_fix;
                else if (ctx_q.fn[1:0] == 2'b00) mdu_result = prod[XLEN-1:0];
                else                        mdu_result = prod[2*XLEN-1:XLEN];
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // MDU datapath: latch operands on launch, step the accumulator while BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
            ctx_q <= '0;
        end else if (launch) begin
            cnt_q <= '0;
            acc_q <= acc_init;
            b_q   <= b_mag;
            ctx_q <= op_ctx;
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= acc_step;
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctl.sv
// Scoreboard bench for alu_mdu_ctl: stimulus pushes expected MDU results,
// a negedge monitor pops and compares whenever mdu_sel is presented.
module tb_alu_mdu_ctl;
    localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            instr_valid = 1'b0;
    logic [31:0]     instruction = '0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [3:0]      alu_op;
    logic            alu_imm, stall, mdu_sel, busy;
    logic [XLEN-1:0] mdu_result;

    alu_mdu_ctl #(.XLEN(XLEN), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
        .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_op(alu_op),
        .alu_imm(alu_imm), .stall(stall), .mdu_sel(mdu_sel), .mdu_result(mdu_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_m(input logic [2:0] f3);
        mk_m = {7'b0000001, 5'd11, 5'd10, f3, 5'd10, 7'b0110011};
    endfunction

    // Monitor: every mdu_sel cycle must match the oldest expected result
    logic [XLEN-1:0] mon_exp;
    always @(negedge clk) begin
        if (mdu_sel) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mdu_unexpected actual=0x%0h required=no_result", mdu_result);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mdu_result !== mon_exp) begin
                    errors++;
                    $display("FAIL mdu_result actual=0x%0h required=0x%0h", mdu_result, mon_exp);
                end
            end
        end
    end

    task automatic dec(input string name, input logic [31:0] ins, input logic iv,
                       input logic [3:0] exp_op, input logic exp_imm);
        @(negedge clk);
        instruction = ins;
        instr_valid = iv;
        #1;
        chk({name, "_op"}, 64'(alu_op), 64'(exp_op));
        chk({name, "_imm"}, 64'(alu_imm), 64'(exp_imm));
        chk({name, "_stall"}, 64'(stall), 64'd0);
        instr_valid = 1'b0;
    endtask

    task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input bit eo,
                           input bit perturb);
        int n;
        int lat;
        @(negedge clk);
        instruction = mk_m(f3);
        rs1_data    = a;
        rs2_data    = b;
        instr_valid = 1'b1;
        exp_q.push_back(res);
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            if (perturb && n == 1) begin
                instr_valid = 1'b0;
                rs1_data    = 32'hDEADBEEF;
                rs2_data    = 32'h0BADF00D;
            end
            #1;
        end
        lat = (EO && eo) ? 1 : XLEN + 1;
        chk({name, "_stall_cycles"}, 64'(n), 64'(lat));
        chk({name, "_done_sel"}, 64'(mdu_sel), 64'd1);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({name, "_back_idle"}, 64'({busy, mdu_sel, stall}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sel", 64'(mdu_sel), 64'd0);
        chk("rst_result", 64'(mdu_result), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        // Base decode
        dec("sub",   32'h40B50533, 1'b1, 4'd1,  1'b0);
        dec("srai",  32'h4025D513, 1'b1, 4'd7,  1'b1);
        dec("add",   32'h00B50533, 1'b1, 4'd0,  1'b0);
        dec("srli",  32'h0025D513, 1'b1, 4'd6,  1'b1);
        dec("sltu",  32'h00B53533, 1'b1, 4'd9,  1'b0);
        dec("sll",   32'h00B51533, 1'b1, 4'd2,  1'b0);
        dec("and",   32'h00B57533, 1'b1, 4'd4,  1'b0);
        dec("xori",  32'h0FF54513, 1'b1, 4'd3,  1'b1);
        dec("lw",    32'h0005A503, 1'b1, 4'd0,  1'b1);
        dec("sw",    32'h00A5A023, 1'b1, 4'd0,  1'b1);
        dec("lui",   32'h123452B7, 1'b1, 4'd15, 1'b1);
        dec("auipc", 32'h00001517, 1'b1, 4'd0,  1'b1);
        dec("beq",   32'h00B50463, 1'b1, 4'd15, 1'b0);
        dec("mul_dec", 32'h02B50533, 1'b0, 4'd15, 1'b0);

        // M-extension results
        run_mop("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0);
        run_mop("div",    3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 0);
        run_mop("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 1);
        run_mop("divu0",  3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1, 0);
        run_mop("remu0",  3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 1, 0);
        run_mop("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_mop("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);
        run_mop("div0s",  3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1, 0);
        run_mop("rem0s",  3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1, 0);
        run_mop("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 1);
        run_mop("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 0);
        run_mop("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
        run_mop("mul0",   3'b000, 32'h00000000, 32'h00001234, 32'h00000000, 1, 0);
        run_mop("divu",   3'b101, 32'd100,      32'd7,        32'd14,       0, 1);
        run_mop("remu",   3'b111, 32'd100,      32'd7,        32'd2,        0, 0);

        // Flush at BUSY cycle 10 of a MUL: no result, back to IDLE
        @(negedge clk);
        instruction = mk_m(3'b000);
        rs1_data    = 32'd5;
        rs2_data    = 32'd6;
        instr_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        instruction = 32'h40B50533;
        #1;
        chk("flush_busy_before", 64'(busy), 64'd1);
        chk("decode_during_busy", 64'(alu_op), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_idle", 64'({busy, stall, mdu_sel}), 64'd0);
        dec("add_after_flush", 32'h00B50533, 1'b1, 4'd0, 1'b0);

        // Flush wins over a same-cycle launch
        @(negedge clk);
        instruction = mk_m(3'b001);
        instr_valid = 1'b1;
        flush       = 1'b1;
        #1;
        chk("flush_launch_stall", 64'(stall), 64'd0);
        @(negedge clk);
        flush       = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("flush_launch_busy", 64'(busy), 64'd0);

        // Reset at BUSY cycle 5 discards the operation
        @(negedge clk);
        instruction = mk_m(3'b011);
        rs1_data    = 32'hFFFFFFFF;
        rs2_data    = 32'h00000002;
        instr_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sel", 64'(mdu_sel), 64'd0);
        chk("midrst_result", 64'(mdu_result), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        run_mop("mulhu_after_rst", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
